wb_dp_ram_burst: RTL and testbench

Single-clock, true dual-port Wishbone B4 RAM for CPU/peripheral shared memory. It is the successor of the current dual-port RAM, with these additions:
- registered-feedback incrementing bursts (CTI/BTE), giving one ack per cycle after the first beat;
- an ERR response for out-of-range addresses, replacing the stall flag;
- deterministic same-word write-collision resolution.

Ports A and B are symmetric. Port A is the CPU side and port B is the DMA/peripheral side.

---
 rtl/wb_dp_ram_burst.sv | 208 ++++++++++++++++++++
 tb/tb_wb_dp_ram_burst.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_dp_ram_burst.sv
// ============================================================================
// wb_dp_ram_burst : true dual-port Wishbone B4 RAM with CTI/BTE bursts and ERR
// Revision 1.0
// ============================================================================
`default_nettype none

module wb_dp_ram_burst_port #(
  parameter int DEPTH      = 4096,
  parameter int ADDR_WIDTH = 14,
  parameter int LSB        = 2,
  parameter int IW         = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] adr,
  input  logic                  we,
  input  logic                  stb,
  input  logic                  cyc,
  input  logic [2:0]            cti,
  input  logic [1:0]            bte,
  output logic                  ack,
  output logic                  err,
  output logic                  rd_en,
  output logic [IW-1:0]         rd_word,
  output logic                  wr_en,
  output logic [IW-1:0]         wr_word
);

  localparam int NW = ADDR_WIDTH - LSB;
  localparam logic [NW:0] DEPTH_W = (NW+1)'(DEPTH);
  localparam logic [NW:0] ONE     = (NW+1)'(1);
  localparam logic [NW:0] M4      = (NW+1)'(3);
  localparam logic [NW:0] M8      = (NW+1)'(7);
  localparam logic [NW:0] M16     = (NW+1)'(15);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t      state;
  logic        ack_r;
  logic        err_r;
  logic [NW:0] nxt;
  logic [NW:0] word;
  logic        word_ok;
  logic        nxt_ok;
  logic        req;
  logic        burst_go;

  // One extra bit so a linear burst stepping past the top is still visible.
  assign word     = {1'b0, adr[ADDR_WIDTH-1:LSB]};
  assign word_ok  = word < DEPTH_W;
  assign nxt_ok   = nxt < DEPTH_W;
  assign req      = cyc & stb & ~ack_r & ~err_r;
  assign ack      = ack_r & cyc & stb;
  assign err      = err_r & cyc & stb;
  assign burst_go = ack & (cti == 3'b010);
  assign wr_en    = ack & we & word_ok & rst_n;
  assign wr_word  = word[IW-1:0];

  generate
    if (LSB > 0) begin : g_unused_lsb
      logic unused_lsb;
      assign unused_lsb = ^adr[LSB-1:0];
    end
  endgenerate

  function automatic logic [NW:0] incr(input logic [NW:0] w, input logic [1:0] b);
    logic [NW:0] m;
    case (b)
      2'b01:   m = M4;
      2'b10:   m = M8;
      2'b11:   m = M16;
      default: m = '1;
    endcase
    return (w & ~m) | ((w + ONE) & m);
  endfunction

  always_comb begin
    rd_en   = 1'b0;
    rd_word = word[IW-1:0];
    if (state == S_IDLE) begin
      rd_en = req & word_ok;
    end else begin
      rd_en   = burst_go & nxt_ok;
      rd_word = nxt[IW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ack_r <= 1'b0;
      err_r <= 1'b0;
      nxt   <= '0;
    end else begin
      ack_r <= 1'b0;
      err_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            if (!word_ok) begin
              err_r <= 1'b1;
            end else begin
              ack_r <= 1'b1;
              if (cti == 3'b010) begin
                state <= S_BURST;
                nxt   <= incr(word, bte);
              end
            end
          end
        end
        S_BURST: begin
          // Any beat that is not a continuing incrementing beat ends the burst.
          state <= S_IDLE;
          if (burst_go) begin
            if (nxt_ok) begin
              ack_r <= 1'b1;
              state <= S_BURST;
              nxt   <= incr(nxt, bte);
            end else begin
              err_r <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

module wb_dp_ram_burst #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 4096,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH   = $clog2(DEPTH * SELECT_WIDTH),
  parameter     INIT_FILE    = ""
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   a_adr_i,
  input  logic [DATA_WIDTH-1:0]   a_dat_i,
  output logic [DATA_WIDTH-1:0]   a_dat_o,
  input  logic                    a_we_i,
  input  logic [SELECT_WIDTH-1:0] a_sel_i,
  input  logic                    a_stb_i,
  input  logic                    a_cyc_i,
  input  logic [2:0]              a_cti_i,
  input  logic [1:0]              a_bte_i,
  output logic                    a_ack_o,
  output logic                    a_err_o,
  input  logic [ADDR_WIDTH-1:0]   b_adr_i,
  input  logic [DATA_WIDTH-1:0]   b_dat_i,
  output logic [DATA_WIDTH-1:0]   b_dat_o,
  input  logic                    b_we_i,
  input  logic [SELECT_WIDTH-1:0] b_sel_i,
  input  logic                    b_stb_i,
  input  logic                    b_cyc_i,
  input  logic [2:0]              b_cti_i,
  input  logic [1:0]              b_bte_i,
  output logic                    b_ack_o,
  output logic                    b_err_o
);

  localparam int LSB = $clog2(SELECT_WIDTH);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic          a_rd, a_wr, b_rd, b_wr;
  logic [IW-1:0] a_rword, a_wword, b_rword, b_wword;

  wb_dp_ram_burst_port #(
    .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .LSB(LSB), .IW(IW)
  ) u_port_a (
    .clk(clk), .rst_n(rst_n), .adr(a_adr_i), .we(a_we_i), .stb(a_stb_i),
    .cyc(a_cyc_i), .cti(a_cti_i), .bte(a_bte_i), .ack(a_ack_o), .err(a_err_o),
    .rd_en(a_rd), .rd_word(a_rword), .wr_en(a_wr), .wr_word(a_wword)
  );

  wb_dp_ram_burst_port #(
    .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .LSB(LSB), .IW(IW)
  ) u_port_b (
    .clk(clk), .rst_n(rst_n), .adr(b_adr_i), .we(b_we_i), .stb(b_stb_i),
    .cyc(b_cyc_i), .cti(b_cti_i), .bte(b_bte_i), .ack(b_ack_o), .err(b_err_o),
    .rd_en(b_rd), .rd_word(b_rword), .wr_en(b_wr), .wr_word(b_wword)
  );

  // Port A is assigned last so its lanes override port B on a shared word.
  always_ff @(posedge clk) begin
    for (int j = 0; j < SELECT_WIDTH; j++) begin
      if (b_wr && b_sel_i[j]) mem[b_wword][j*8 +: 8] <= b_dat_i[j*8 +: 8];
      if (a_wr && a_sel_i[j]) mem[a_wword][j*8 +: 8] <= a_dat_i[j*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_dat_o <= '0;
      b_dat_o <= '0;
    end else begin
      if (a_rd) a_dat_o <= mem[a_rword];
      if (b_rd) b_dat_o <= mem[b_rword];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_dp_ram_burst.sv
// Bench for wb_dp_ram_burst: transaction-level masters on both ports, a word-array
// memory model applied per clock edge, and a per-cycle output compare.
`default_nettype none

module tb_wb_dp_ram_burst;

  localparam int DW    = 32;
  localparam int DEPTH = 40;
  localparam int SW    = 4;
  localparam int AW    = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [AW-1:0] adr   [2];
  logic [DW-1:0] dati  [2];
  logic [SW-1:0] sel   [2];
  logic          we_s  [2];
  logic          stb   [2];
  logic          cyc   [2];
  logic [2:0]    cti   [2];
  logic [1:0]    bte_s [2];

  wire [DW-1:0] dato_a, dato_b;
  wire          ack_a, ack_b, err_a, err_b;

  wb_dp_ram_burst #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .SELECT_WIDTH(SW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .a_adr_i(adr[0]), .a_dat_i(dati[0]), .a_dat_o(dato_a), .a_we_i(we_s[0]),
    .a_sel_i(sel[0]), .a_stb_i(stb[0]), .a_cyc_i(cyc[0]), .a_cti_i(cti[0]),
    .a_bte_i(bte_s[0]), .a_ack_o(ack_a), .a_err_o(err_a),
    .b_adr_i(adr[1]), .b_dat_i(dati[1]), .b_dat_o(dato_b), .b_we_i(we_s[1]),
    .b_sel_i(sel[1]), .b_stb_i(stb[1]), .b_cyc_i(cyc[1]), .b_cti_i(cti[1]),
    .b_bte_i(bte_s[1]), .b_ack_o(ack_b), .b_err_o(err_b)
  );

  // Reference state: memory words, plus what each master declares for the next edge.
  logic [DW-1:0] model_mem [DEPTH];
  logic          rd_v [2];
  int            rd_w [2];
  logic          wr_v [2];
  int            wr_w [2];
  logic [DW-1:0] wr_d [2];
  logic [SW-1:0] wr_s [2];
  logic [DW-1:0] exp_dat [2];
  logic          exp_ack [2];
  logic          exp_err [2];

  logic [DW-1:0] cap_dat [2][64];
  int            cap_n [2];
  int            nack  [2];
  int            nerr  [2];

  int   n_checks = 0;
  int   n_fail   = 0;
  logic chk_on   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int next_w(input int w, input logic [1:0] b);
    int n;
    n = (b == 2'd0) ? 0 : (b == 2'd1) ? 4 : (b == 2'd2) ? 8 : 16;
    if (n == 0) return w + 1;
    return (w / n) * n + ((w % n) + 1) % n;
  endfunction

  // Read-first memory model: reads see the array before this edge's writes.
  initial begin : model_proc
    logic [DW-1:0] r [2];
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        exp_dat[0] = '0;
        exp_dat[1] = '0;
      end else begin
        r[0] = exp_dat[0];
        r[1] = exp_dat[1];
        for (int p = 0; p < 2; p++)
          if (rd_v[p]) r[p] = model_mem[rd_w[p]];
        for (int p = 1; p >= 0; p--)
          if (wr_v[p])
            for (int j = 0; j < SW; j++)
              if (wr_s[p][j]) model_mem[wr_w[p]][j*8 +: 8] = wr_d[p][j*8 +: 8];
        exp_dat[0] = r[0];
        exp_dat[1] = r[1];
      end
    end
  end

  initial begin : compare_proc
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("ack_a", ack_a, exp_ack[0]);
        chk("err_a", err_a, exp_err[0]);
        chk("ack_b", ack_b, exp_ack[1]);
        chk("err_b", err_b, exp_err[1]);
        if (!$isunknown(exp_dat[0])) chk("dat_a", dato_a, exp_dat[0]);
        if (!$isunknown(exp_dat[1])) chk("dat_b", dato_b, exp_dat[1]);
      end
    end
  end

  // One classic access (burst=0) or an n-beat incrementing burst. rst_at >= 0
  // asserts reset during that beat's ack cycle.
  task automatic xfer(input int p, input logic burst, input int n, input logic [1:0] bt,
                      input logic we, input int start, input logic [DW-1:0] d0,
                      input logic [SW-1:0] s0, input logic rnd, input int rst_at);
    int w, nw;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    w = start; cap_n[p] = 0; nack[p] = 0; nerr[p] = 0;
    d = rnd ? DW'($urandom) : d0;
    s = rnd ? SW'($urandom) : s0;
    cyc[p] = 1'b1; stb[p] = 1'b1; we_s[p] = we; adr[p] = AW'(w * SW);
    cti[p] = burst ? 3'b010 : 3'b000; bte_s[p] = bt; dati[p] = d; sel[p] = s;
    exp_ack[p] = 1'b0; exp_err[p] = 1'b0;
    rd_v[p] = (w < DEPTH); rd_w[p] = w; wr_v[p] = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (w >= DEPTH) begin
        exp_err[p] = 1'b1; exp_ack[p] = 1'b0; rd_v[p] = 1'b0; wr_v[p] = 1'b0;
        nerr[p]++;
        break;
      end
      exp_ack[p] = 1'b1; exp_err[p] = 1'b0; nack[p]++;
      cap_dat[p][cap_n[p]] = (p == 0) ? dato_a : dato_b;
      cap_n[p]++;
      if (i > 0) begin
        d = rnd ? DW'($urandom) : d0 + DW'(i);
        s = rnd ? SW'($urandom) : s0;
      end
      adr[p] = AW'(w * SW); dati[p] = d; sel[p] = s;
      cti[p] = !burst ? 3'b000 : (i == n - 1) ? 3'b111 : 3'b010;
      wr_v[p] = we; wr_w[p] = w; wr_d[p] = d; wr_s[p] = s;
      nw = next_w(w, bt);
      rd_v[p] = burst && (i < n - 1) && (nw < DEPTH);
      rd_w[p] = nw;
      if (i == rst_at) begin
        rst_n = 1'b0; rd_v[p] = 1'b0; wr_v[p] = 1'b0;
        break;
      end
      w = nw;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc[p] = 1'b0; stb[p] = 1'b0; we_s[p] = 1'b0; cti[p] = 3'b000;
    exp_ack[p] = 1'b0; exp_err[p] = 1'b0; rd_v[p] = 1'b0; wr_v[p] = 1'b0;
  endtask

  task automatic idle(input int c);
    repeat (c) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin : main_proc
    rst_n = 1'b0;
    for (int p = 0; p < 2; p++) begin
      adr[p] = '0; dati[p] = '0; sel[p] = '0; we_s[p] = 1'b0; stb[p] = 1'b0;
      cyc[p] = 1'b0; cti[p] = 3'b000; bte_s[p] = 2'b00;
      rd_v[p] = 1'b0; wr_v[p] = 1'b0; rd_w[p] = 0; wr_w[p] = 0;
      wr_d[p] = '0; wr_s[p] = '0;
      exp_ack[p] = 1'b0; exp_err[p] = 1'b0; exp_dat[p] = '0;
    end
    @(posedge clk); #1;
    chk_on = 1'b1;
    chk("rst_dat_a", dato_a, 0);
    chk("rst_ack_b", ack_b, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fill every word with a known pattern through one long linear burst.
    xfer(0, 1, DEPTH, 2'b00, 1, 0, 32'h1000_0000, 4'hF, 0, -1);
    chk("fill_acks", nack[0], DEPTH);

    xfer(0, 0, 1, 2'b00, 1, 4, 32'hDEADBEEF, 4'hF, 0, -1);
    xfer(0, 0, 1, 2'b00, 0, 4, '0, '0, 0, -1);
    chk("classic_rd", cap_dat[0][0], 32'hDEADBEEF);

    xfer(0, 0, 1, 2'b00, 1, 8, 32'hAABBCCDD, 4'hF, 0, -1);
    xfer(0, 0, 1, 2'b00, 1, 8, 32'h11223344, 4'h5, 0, -1);
    xfer(0, 0, 1, 2'b00, 0, 8, '0, '0, 0, -1);
    chk("byte_lanes", cap_dat[0][0], 32'hAA22CC44);

    xfer(1, 1, 4, 2'b00, 1, 8, 32'h100, 4'hF, 0, -1);
    xfer(1, 1, 4, 2'b00, 0, 8, '0, '0, 0, -1);
    chk("lin_acks", nack[1], 4);
    for (int i = 0; i < 4; i++) chk("lin_rd", cap_dat[1][i], 32'h100 + i);

    xfer(0, 1, 4, 2'b00, 1, 4, 32'h4, 4'hF, 0, -1);
    xfer(0, 1, 4, 2'b01, 0, 6, '0, '0, 0, -1);
    chk("wrap4_0", cap_dat[0][0], 32'h6);
    chk("wrap4_1", cap_dat[0][1], 32'h7);
    chk("wrap4_2", cap_dat[0][2], 32'h4);
    chk("wrap4_3", cap_dat[0][3], 32'h5);
    chk("wrap4_err", nerr[0], 0);

    xfer(0, 0, 1, 2'b00, 0, DEPTH, '0, '0, 0, -1);
    chk("oor_err", nerr[0], 1);
    chk("oor_ack", nack[0], 0);
    xfer(1, 0, 1, 2'b00, 1, DEPTH, 32'hFFFF_FFFF, 4'hF, 0, -1);
    xfer(1, 1, 4, 2'b00, 0, DEPTH - 2, '0, '0, 0, -1);
    chk("oor_burst_ack", nack[1], 2);
    chk("oor_burst_err", nerr[1], 1);

    fork
      xfer(0, 0, 1, 2'b00, 1, 3, 32'h0000_00AA, 4'h1, 0, -1);
      xfer(1, 0, 1, 2'b00, 1, 3, 32'hBBBB_BBBB, 4'hF, 0, -1);
    join
    xfer(0, 0, 1, 2'b00, 0, 3, '0, '0, 0, -1);
    chk("ww_collide", cap_dat[0][0], 32'hBBBB_BBAA);

    fork
      xfer(0, 0, 1, 2'b00, 0, 5, '0, '0, 0, -1);
      xfer(1, 0, 1, 2'b00, 1, 5, 32'h55, 4'hF, 0, -1);
    join
    chk("rw_old", cap_dat[0][0], 32'h5);
    xfer(0, 0, 1, 2'b00, 0, 5, '0, '0, 0, -1);
    chk("rw_new", cap_dat[0][0], 32'h55);

    xfer(0, 1, 8, 2'b00, 0, 0, '0, '0, 0, 2);
    chk("rst_burst_acks", nack[0], 3);
    idle(3);
    chk("rst_burst_dat", dato_a, 0);

    fork
      begin
        for (int t = 0; t < 150; t++) begin
          int w, k;
          k = $urandom_range(0, 3);
          w = ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH + 3) : $urandom_range(0, 7);
          xfer(0, k >= 2, (k >= 2) ? $urandom_range(1, 6) : 1, 2'($urandom),
               1'($urandom), w, '0, '0, 1, -1);
          idle($urandom_range(0, 2));
        end
      end
      begin
        for (int t = 0; t < 150; t++) begin
          int w, k;
          k = $urandom_range(0, 3);
          w = ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH + 3) : $urandom_range(0, 7);
          xfer(1, k >= 2, (k >= 2) ? $urandom_range(1, 6) : 1, 2'($urandom),
               1'($urandom), w, '0, '0, 1, -1);
          idle($urandom_range(0, 2));
        end
      end
    join

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
